// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/stall controller.
package hazard_pkg;
  localparam int REG_W          = 5;
  localparam int MD_TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic {IDLE, MD_WAIT} state_t;
endpackage

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Load-use hazard detection between the EX-stage load and the ID-stage sources.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic             IDEX_MemoryRead,
  input  logic [REG_W-1:0] IDEX_rd,
  input  logic [REG_W-1:0] IFID_rs1,
  input  logic [REG_W-1:0] IFID_rs2,
  output logic             load_use
);
  // x0 is hardwired zero, so a load into it never creates a dependency.
  assign load_use = IDEX_MemoryRead && (IDEX_rd != '0) &&
                    ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
endmodule

// File: rtl/hazard_stall_controller.sv
// Execute-stage hazard/stall sequencer: load-use bubbles and mul/div freeze.
// Optional mul/div watchdog enabled by defining HAZARD_WATCHDOG_EN.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDEX_MemoryRead,
  input  logic             IDEX_MulDiv,
  input  logic [REG_W-1:0] IDEX_rd,
  input  logic [REG_W-1:0] IFID_rs1,
  input  logic [REG_W-1:0] IFID_rs2,
  input  logic             md_done,
  output logic             md_start,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             IDEX_flush,
  output logic             EXMEM_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             md_timeout
);
  state_t state, state_nxt;
  logic   load_use;
  logic   timeout_hit;
  logic   md_release;

  load_use_detect u_load_use (
    .IDEX_MemoryRead (IDEX_MemoryRead),
    .IDEX_rd         (IDEX_rd),
    .IFID_rs1        (IFID_rs1),
    .IFID_rs2        (IFID_rs2),
    .load_use        (load_use)
  );

`ifdef HAZARD_WATCHDOG_EN
  localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;

  // wait_cnt holds the number of MD_WAIT cycles already completed.
  assign timeout_hit = (state == MD_WAIT) && !md_done &&
                       (wait_cnt == WAIT_W'(MD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= (state == MD_WAIT && state_nxt == MD_WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
  assign md_timeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign md_timeout  = 1'b0;
`endif

  assign md_release = md_done || timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    md_start     = 1'b0;
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IDEX_write   = 1'b1;
    IDEX_flush   = 1'b0;
    EXMEM_bubble = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          // MulDiv outranks load_use; md_done is meaningless here.
          if (IDEX_MulDiv) begin
            md_start     = 1'b1;
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_bubble = 1'b1;
            state_nxt    = MD_WAIT;
          end else if (load_use) begin
            PC_write   = 1'b0;
            IFID_write = 1'b0;
            IDEX_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_release) begin
            state_nxt = IDLE;
          end else begin
            PC_write     = 1'b0;
            IFID_write   = 1'b0;
            IDEX_write   = 1'b0;
            EXMEM_bubble = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   stall_cycles <= '0;
    else if (!PC_write && stall_cycles != '1)  stall_cycles <= stall_cycles + 1'b1;
  end
endmodule
